// File: rtl/top.sv
// rtl/top.sv - PDP-8 subset CPU with front-panel buttons, 4096x12 memory and octal 7-seg display
// Optional Group 3 MQ microinstructions are enabled by defining GROUP3_MQ_EN.
module top (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        btnc,
  input  logic        btnu,
  input  logic        btnd,
  input  logic        btnl,
  input  logic        btnr,
  input  logic [12:0] sw,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  typedef enum logic [2:0] {IDLE, FETCH, DEFER, EXEC, WRITEBACK, HALT} state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_OPR = 3'd7;

  logic rst_n;
  assign rst_n = btnCpuReset;

  state_t      state_q, state_d;
  logic [11:0] ac_q, ac_d, pc_q, pc_d, ir_q, ir_d, ea_q, ea_d, wb_q, wb_d;
  logic        l_q, l_d, run_q, run_d, hlt_q, hlt_d, step_q, step_d;
  logic        done_q, done_d, sel_q, sel_d;
  logic [5:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, rise;
  logic [17:0] scan_q, scan_d;
`ifdef GROUP3_MQ_EN
  logic [11:0] mq_q, mq_d;
  logic [11:0] g3_ac;
`endif

  logic [11:0] mem [0:4095];
  logic        valid [0:4095];
  logic        mem_we;
  logic [11:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

  logic [12:0] lac, sum;
  logic        skip, finish, halt_req;
  logic [11:0] disp;
  logic [2:0]  digit;

  // Bit order: 0 btnc, 1 btnu, 2 btnd, 3 btnl, 4 btnr, 5 run switch.
  always_comb begin
    sync1_d = {sw[12], btnr, btnl, btnd, btnu, btnc};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
  end

  // Words never written read as zero so an unloaded location behaves as AND 0.
  assign mem_raddr = (state_q == FETCH) ? pc_q : ea_q;
  assign mem_rdata = valid[mem_raddr] ? mem[mem_raddr] : 12'd0;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr]   <= mem_wdata;
      valid[mem_waddr] <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ac_d      = ac_q;
    l_d       = l_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ea_d      = ea_q;
    wb_d      = wb_q;
    run_d     = run_q;
    hlt_d     = hlt_q;
    step_d    = step_q;
    done_d    = 1'b0;
    sel_d     = sel_q ^ rise[0];
    scan_d    = scan_q + 18'd1;
`ifdef GROUP3_MQ_EN
    mq_d      = mq_q;
    g3_ac     = 12'd0;
`endif
    mem_we    = 1'b0;
    mem_waddr = ea_q;
    mem_wdata = wb_q;
    lac       = {l_q, ac_q};
    sum       = 13'd0;
    skip      = 1'b0;
    finish    = 1'b0;
    halt_req  = 1'b0;

    case (state_q)
      IDLE, HALT: begin
        if (rise[5]) begin
          run_d   = 1'b1;
          hlt_d   = 1'b0;
          state_d = FETCH;
        end else if (rise[1]) begin
          step_d  = 1'b1;
          hlt_d   = 1'b0;
          state_d = FETCH;
        end else if (rise[3]) begin
          pc_d = sw[11:0];
        end else if (rise[4]) begin
          ac_d = sw[11:0];
        end else if (rise[2]) begin
          mem_we    = 1'b1;
          mem_waddr = pc_q;
          mem_wdata = sw[11:0];
          pc_d      = pc_q + 12'd1;
        end
      end
      FETCH: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 12'd1;
        ea_d    = {(mem_rdata[7] ? pc_q[11:7] : 5'd0), mem_rdata[6:0]};
        state_d = (mem_rdata[11:9] < 3'd6 && mem_rdata[8]) ? DEFER : EXEC;
      end
      DEFER: begin
        ea_d    = mem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        case (ir_q[11:9])
          OP_AND: begin
            ac_d   = ac_q & mem_rdata;
            finish = 1'b1;
          end
          OP_TAD: begin
            sum    = {1'b0, ac_q} + {1'b0, mem_rdata};
            ac_d   = sum[11:0];
            l_d    = l_q ^ sum[12];
            finish = 1'b1;
          end
          OP_ISZ: begin
            wb_d    = mem_rdata + 12'd1;
            state_d = WRITEBACK;
          end
          OP_DCA: begin
            wb_d    = ac_q;
            ac_d    = 12'd0;
            state_d = WRITEBACK;
          end
          OP_JMS: begin
            wb_d    = pc_q;
            pc_d    = ea_q + 12'd1;
            state_d = WRITEBACK;
          end
          OP_JMP: begin
            pc_d   = ea_q;
            finish = 1'b1;
          end
          OP_OPR: begin
            finish = 1'b1;
            if (!ir_q[8]) begin
              if (ir_q[7]) lac[11:0] = 12'd0;
              if (ir_q[6]) lac[12] = 1'b0;
              if (ir_q[5]) lac[11:0] = ~lac[11:0];
              if (ir_q[4]) lac[12] = ~lac[12];
              if (ir_q[0]) lac = lac + 13'd1;
              if (ir_q[3]) begin
                lac = {lac[0], lac[12:1]};
                if (ir_q[1]) lac = {lac[0], lac[12:1]};
              end else if (ir_q[2]) begin
                lac = {lac[11:0], lac[12]};
                if (ir_q[1]) lac = {lac[11:0], lac[12]};
              end
              l_d  = lac[12];
              ac_d = lac[11:0];
            end else if (!ir_q[0]) begin
              skip = (ir_q[6] & ac_q[11]) | (ir_q[5] & (ac_q == 12'd0)) | (ir_q[4] & l_q);
              if (ir_q[3]) skip = ~skip;
              if (skip) pc_d = pc_q + 12'd1;
              ac_d = ir_q[7] ? 12'd0 : ac_q;
              if (ir_q[2]) ac_d = ac_d | sw[11:0];
              halt_req = ir_q[1];
            end else begin
`ifdef GROUP3_MQ_EN
              // MQL and MQA together form SWP because MQA reads the old MQ.
              g3_ac = ir_q[7] ? 12'd0 : ac_q;
              if (ir_q[4]) mq_d = g3_ac;
              ac_d = (ir_q[4] ? 12'd0 : g3_ac) | (ir_q[6] ? mq_q : 12'd0);
`else
              ac_d = ac_q;
`endif
            end
          end
          default: finish = 1'b1;
        endcase
      end
      WRITEBACK: begin
        mem_we    = 1'b1;
        mem_waddr = ea_q;
        mem_wdata = wb_q;
        if (ir_q[11:9] == OP_ISZ && wb_q == 12'd0) pc_d = pc_q + 12'd1;
        finish = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      done_d = 1'b1;
      if (halt_req) begin
        state_d = HALT;
        run_d   = 1'b0;
        hlt_d   = 1'b1;
        step_d  = 1'b0;
      end else if (step_q || !sync2_q[5]) begin
        state_d = IDLE;
        run_d   = 1'b0;
        step_d  = 1'b0;
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ac_q    <= 12'd0;
      l_q     <= 1'b0;
      pc_q    <= 12'd0;
      ir_q    <= 12'd0;
      ea_q    <= 12'd0;
      wb_q    <= 12'd0;
      run_q   <= 1'b0;
      hlt_q   <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      sync1_q <= 6'd0;
      sync2_q <= 6'd0;
      prev_q  <= 6'd0;
      scan_q  <= 18'd0;
`ifdef GROUP3_MQ_EN
      mq_q    <= 12'd0;
`endif
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      l_q     <= l_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ea_q    <= ea_d;
      wb_q    <= wb_d;
      run_q   <= run_d;
      hlt_q   <= hlt_d;
      step_q  <= step_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      scan_q  <= scan_d;
`ifdef GROUP3_MQ_EN
      mq_q    <= mq_d;
`endif
    end
  end

  assign led = {hlt_q, l_q, done_q, run_q, ac_q};

  // Digit 0 (rightmost) holds the least significant octal digit.
  always_comb begin
    disp = sel_q ? pc_q : ac_q;
    case (scan_q[17:16])
      2'd0:    digit = disp[2:0];
      2'd1:    digit = disp[5:3];
      2'd2:    digit = disp[8:6];
      default: digit = disp[11:9];
    endcase
    an = {4'hF, ~(4'b0001 << scan_q[17:16])};
    dp = 1'b1;
    case (digit)
      3'd0:    seg = 7'b1000000;
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      3'd5:    seg = 7'b0010010;
      3'd6:    seg = 7'b0000010;
      default: seg = 7'b1111000;
    endcase
  end
endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed self-checking bench for the PDP-8 subset panel CPU
module tb_top;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        btnc, btnu, btnd, btnl, btnr;
  logic [12:0] sw;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int   checks = 0;
  int   fails  = 0;
  int   pulses;
  logic tmo;

  top dut (
    .clk(clk), .btnCpuReset(rst_n), .btnc(btnc), .btnu(btnu), .btnd(btnd),
    .btnl(btnl), .btnr(btnr), .sw(sw), .led(led), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press(input int b);
    @(negedge clk);
    case (b)
      0: btnc = 1'b1;
      1: btnu = 1'b1;
      2: btnd = 1'b1;
      3: btnl = 1'b1;
      default: btnr = 1'b1;
    endcase
    repeat (4) @(negedge clk);
    btnc = 1'b0; btnu = 1'b0; btnd = 1'b0; btnl = 1'b0; btnr = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic set_pc(input logic [11:0] a);
    sw[11:0] = a;
    press(3);
  endtask

  task automatic set_ac(input logic [11:0] a);
    sw[11:0] = a;
    press(4);
  endtask

  task automatic dep(input logic [11:0] w);
    sw[11:0] = w;
    press(2);
  endtask

  task automatic run_prog(input int budget);
    logic seen;
    int   n;
    pulses = 0; tmo = 1'b1; seen = 1'b0; n = 0;
    sw[12] = 1'b0;
    repeat (4) @(negedge clk);
    sw[12] = 1'b1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (led[13] === 1'b1) pulses++;
      if (led[12] === 1'b1) seen = 1'b1;
      if (seen && led[12] === 1'b0) begin
        tmo = 1'b0;
        break;
      end
    end
    sw[12] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btnc = 0; btnu = 0; btnd = 0; btnl = 0; btnr = 0; sw = 13'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (led !== 16'h0000) begin fails++; $display("FAIL reset_led: got %h want 0000", led); end
    checks++; if (an !== 8'hFE) begin fails++; $display("FAIL reset_an: got %h want fe", an); end
    checks++; if (seg !== 7'b1000000) begin fails++; $display("FAIL reset_seg: got %b want 1000000", seg); end
    checks++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b want 1", dp); end
    checks++; if (dut.pc_q !== 12'o0000) begin fails++; $display("FAIL reset_pc: got %o want 0000", dut.pc_q); end
  endtask

  task automatic test_basic;
    set_pc(12'o0200);
    dep(12'o7300); dep(12'o1205); dep(12'o7001); dep(12'o7402); dep(12'o0000); dep(12'o0005);
    checks++; if (dut.pc_q !== 12'o0206) begin fails++; $display("FAIL deposit_pc: got %o want 0206", dut.pc_q); end
    set_pc(12'o0200);
    run_prog(500);
    checks++; if (tmo !== 1'b0) begin fails++; $display("FAIL basic_timeout: got %b want 0", tmo); end
    checks++; if (led[11:0] !== 12'o0006) begin fails++; $display("FAIL basic_ac: got %o want 0006", led[11:0]); end
    checks++; if (led[12] !== 1'b0) begin fails++; $display("FAIL basic_running: got %b want 0", led[12]); end
    checks++; if (led[15] !== 1'b1) begin fails++; $display("FAIL basic_halted: got %b want 1", led[15]); end
    checks++; if (pulses !== 4) begin fails++; $display("FAIL basic_pulses: got %0d want 4", pulses); end
    checks++; if (dut.pc_q !== 12'o0204) begin fails++; $display("FAIL basic_pc: got %o want 0204", dut.pc_q); end
  endtask

  task automatic test_display;
    checks++; if (seg !== 7'b0000010) begin fails++; $display("FAIL disp_ac: got %b want 0000010", seg); end
    press(0);
    checks++; if (seg !== 7'b0011001) begin fails++; $display("FAIL disp_pc: got %b want 0011001", seg); end
    checks++; if (an !== 8'hFE) begin fails++; $display("FAIL disp_an: got %h want fe", an); end
    press(0);
    checks++; if (seg !== 7'b0000010) begin fails++; $display("FAIL disp_back: got %b want 0000010", seg); end
  endtask

  task automatic test_rotate;
    set_ac(12'o0000);
    set_pc(12'o0200);
    dep(12'o7120); dep(12'o7010); dep(12'o7402);
    set_pc(12'o0200);
    run_prog(500);
    checks++; if (tmo !== 1'b0) begin fails++; $display("FAIL rot_timeout: got %b want 0", tmo); end
    checks++; if (led[11:0] !== 12'o4000) begin fails++; $display("FAIL rot_ac: got %o want 4000", led[11:0]); end
    checks++; if (led[14] !== 1'b0) begin fails++; $display("FAIL rot_link: got %b want 0", led[14]); end
    checks++; if (pulses !== 3) begin fails++; $display("FAIL rot_pulses: got %0d want 3", pulses); end
  endtask

  task automatic test_isz;
    set_pc(12'o0200);
    dep(12'o2210); dep(12'o7402); dep(12'o7402);
    set_pc(12'o0210);
    dep(12'o7777);
    set_pc(12'o0200);
    run_prog(500);
    checks++; if (tmo !== 1'b0) begin fails++; $display("FAIL isz_timeout: got %b want 0", tmo); end
    checks++; if (dut.mem[12'o0210] !== 12'o0000) begin fails++; $display("FAIL isz_mem: got %o want 0000", dut.mem[12'o0210]); end
    checks++; if (dut.pc_q !== 12'o0203) begin fails++; $display("FAIL isz_skip_pc: got %o want 0203", dut.pc_q); end
    checks++; if (pulses !== 2) begin fails++; $display("FAIL isz_pulses: got %0d want 2", pulses); end
    set_pc(12'o0200);
    run_prog(500);
    checks++; if (dut.mem[12'o0210] !== 12'o0001) begin fails++; $display("FAIL isz_mem2: got %o want 0001", dut.mem[12'o0210]); end
    checks++; if (dut.pc_q !== 12'o0202) begin fails++; $display("FAIL isz_noskip_pc: got %o want 0202", dut.pc_q); end
  endtask

  task automatic test_jms_jmp;
    set_pc(12'o0200); dep(12'o4220);
    set_pc(12'o0221); dep(12'o5630);
    set_pc(12'o0230); dep(12'o0300);
    set_pc(12'o0300); dep(12'o7402);
    set_pc(12'o0200);
    press(1);
    checks++; if (dut.mem[12'o0220] !== 12'o0201) begin fails++; $display("FAIL jms_mem: got %o want 0201", dut.mem[12'o0220]); end
    checks++; if (dut.pc_q !== 12'o0221) begin fails++; $display("FAIL jms_pc: got %o want 0221", dut.pc_q); end
    checks++; if (led[12] !== 1'b0 || led[15] !== 1'b0) begin fails++; $display("FAIL step_idle: got run=%b hlt=%b want 0 0", led[12], led[15]); end
    press(1);
    checks++; if (dut.pc_q !== 12'o0300) begin fails++; $display("FAIL jmpi_pc: got %o want 0300", dut.pc_q); end
    press(1);
    checks++; if (led[15] !== 1'b1) begin fails++; $display("FAIL step_hlt: got %b want 1", led[15]); end
  endtask

  task automatic test_skip;
    set_pc(12'o0200);
    dep(12'o7300); dep(12'o7440); dep(12'o7402); dep(12'o7120);
    dep(12'o7010); dep(12'o7510); dep(12'o7406); dep(12'o7402);
    set_pc(12'o0200);
    sw[11:0] = 12'o0017;
    run_prog(500);
    checks++; if (tmo !== 1'b0) begin fails++; $display("FAIL skip_timeout: got %b want 0", tmo); end
    checks++; if (led[11:0] !== 12'o4017) begin fails++; $display("FAIL skip_ac: got %o want 4017", led[11:0]); end
    checks++; if (dut.pc_q !== 12'o0207) begin fails++; $display("FAIL skip_pc: got %o want 0207", dut.pc_q); end
    checks++; if (pulses !== 6) begin fails++; $display("FAIL skip_pulses: got %0d want 6", pulses); end
  endtask

  task automatic test_group3;
    logic [11:0] exp_mql;
`ifdef GROUP3_MQ_EN
    exp_mql = 12'o0000;
`else
    exp_mql = 12'o1234;
`endif
    set_pc(12'o0200);
    dep(12'o7421); dep(12'o7501); dep(12'o7402);
    set_ac(12'o1234);
    set_pc(12'o0200);
    press(1);
    checks++; if (led[11:0] !== exp_mql) begin fails++; $display("FAIL g3_mql_ac: got %o want %o", led[11:0], exp_mql); end
    press(1);
    checks++; if (led[11:0] !== 12'o1234) begin fails++; $display("FAIL g3_mqa_ac: got %o want 1234", led[11:0]); end
`ifdef GROUP3_MQ_EN
    checks++; if (dut.mq_q !== 12'o1234) begin fails++; $display("FAIL g3_mq: got %o want 1234", dut.mq_q); end
`endif
  endtask

  task automatic test_panel_running;
    int n;
    set_pc(12'o0200); dep(12'o5200);
    set_ac(12'o0000);
    set_pc(12'o0200);
    sw[12] = 1'b0;
    repeat (4) @(negedge clk);
    sw[12] = 1'b1;
    n = 0;
    while (led[12] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (led[12] !== 1'b1) begin fails++; $display("FAIL loop_start: got %b want 1", led[12]); end
    set_ac(12'o7777);
    set_pc(12'o0500);
    checks++; if (led[11:0] !== 12'o0000) begin fails++; $display("FAIL panel_ignored_ac: got %o want 0000", led[11:0]); end
    sw[12] = 1'b0;
    n = 0;
    while (led[12] !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    checks++; if (led[12] !== 1'b0) begin fails++; $display("FAIL loop_stop: got %b want 0", led[12]); end
    checks++; if (led[15] !== 1'b0) begin fails++; $display("FAIL loop_stop_hlt: got %b want 0", led[15]); end
    checks++; if (dut.pc_q !== 12'o0200) begin fails++; $display("FAIL loop_stop_pc: got %o want 0200", dut.pc_q); end
  endtask

  task automatic test_reset_midrun;
    int n;
    set_pc(12'o0200); dep(12'o3220); dep(12'o5200);
    set_pc(12'o0220); dep(12'o1111);
    set_ac(12'o2222);
    set_pc(12'o0200);
    sw[12] = 1'b0;
    repeat (4) @(negedge clk);
    sw[12] = 1'b1;
    n = 0;
    while (!(dut.mem_we === 1'b1 && led[12] === 1'b1) && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin fails++; $display("FAIL midrun_wait: got %0d cycles want <100", n); end
    rst_n  = 1'b0;
    sw[12] = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dut.mem[12'o0220] !== 12'o1111) begin fails++; $display("FAIL abort_nowrite: got %o want 1111", dut.mem[12'o0220]); end
    checks++; if (dut.mem[12'o0201] !== 12'o5200) begin fails++; $display("FAIL mem_preserved: got %o want 5200", dut.mem[12'o0201]); end
    checks++; if (led !== 16'h0000) begin fails++; $display("FAIL midrun_led: got %h want 0000", led); end
    checks++; if (dut.pc_q !== 12'o0000) begin fails++; $display("FAIL midrun_pc: got %o want 0000", dut.pc_q); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_display();
    test_rotate();
    test_isz();
    test_jms_jmp();
    test_skip();
    test_group3();
    test_panel_running();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
